// File: rtl/i2c_sync_fifo.sv
// Synchronous first-word-fall-through byte FIFO that sits between the APB register block and the I2C core.
// It provides the count, flag and sticky-status decodes used by the APB status register.
module i2c_sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = 14,
  parameter int AE_LEVEL   = 2
) (
  input  logic                       pclk_i,
  input  logic                       preset_ni,
  input  logic                       clear_i,
  input  logic                       wr_en_i,
  input  logic [DATA_WIDTH-1:0]      wr_data_i,
  input  logic                       rd_en_i,
  output logic [DATA_WIDTH-1:0]      rd_data_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [7:0]                 status_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_almost_full;
  logic                  w_almost_empty;
  logic                  w_pop;
  logic                  w_push;

  assign w_full         = (r_count == CW'(DEPTH));
  assign w_empty        = (r_count == {CW{1'b0}});
  assign w_almost_full  = (r_count >= CW'(AF_LEVEL));
  assign w_almost_empty = (r_count <= CW'(AE_LEVEL));

  // A full FIFO still accepts a write when a read frees a slot in the same cycle.
  assign w_pop  = rd_en_i & ~w_empty;
  assign w_push = wr_en_i & (~w_full | w_pop);

  // Pointer, occupancy and sticky-error state; clear_i overrides any transfer.
  always_ff @(posedge pclk_i or negedge preset_ni) begin
    if (!preset_ni) begin
      r_wr_ptr    <= {AW{1'b0}};
      r_rd_ptr    <= {AW{1'b0}};
      r_count     <= {CW{1'b0}};
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (clear_i) begin
      r_wr_ptr    <= {AW{1'b0}};
      r_rd_ptr    <= {AW{1'b0}};
      r_count     <= {CW{1'b0}};
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (wr_en_i & w_full & ~rd_en_i) r_overflow  <= 1'b1;
      if (rd_en_i & w_empty)           r_underflow <= 1'b1;
    end
  end

  // Storage array; it is not reset, and a flush leaves its contents stale.
  always_ff @(posedge pclk_i) begin
    if (!clear_i && w_push) begin
      r_mem[r_wr_ptr] <= wr_data_i;
    end
  end

  assign rd_data_o = w_empty ? {DATA_WIDTH{1'b0}} : r_mem[r_rd_ptr];
  assign count_o   = r_count;
  assign full_o    = w_full;
  assign empty_o   = w_empty;
  assign status_o  = {2'b00, r_underflow, r_overflow, w_almost_full, w_almost_empty, w_full, w_empty};

endmodule
